// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

   localparam int unsigned DEF_N_REQ       = 4;
   localparam int unsigned DEF_DATA_W      = 8;
   localparam int unsigned DEF_TIMEOUT_CYC = 4096;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StLoad     = 2'd1,
      StWaitDone = 2'd2
   } arb_state_e;

   function automatic int unsigned rr_wrap(input int unsigned base, input int unsigned off,
                                           input int unsigned n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request above the last grant, with wrap.
module uart_rr_picker
   import uart_arb_pkg::*;
#(
   parameter int unsigned N_REQ = DEF_N_REQ,
   parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_last_gnt,
   output logic [IDX_W-1:0] o_winner,
   output logic             o_valid
);

   // Walk from the farthest candidate to the nearest so the nearest set bit wins.
   always_comb begin
      o_valid  = 1'b0;
      o_winner = '0;
      for (int unsigned off = N_REQ; off >= 1; off--) begin
         if (i_req[IDX_W'(rr_wrap(32'(i_last_gnt), off, N_REQ))]) begin
            o_valid  = 1'b1;
            o_winner = IDX_W'(rr_wrap(32'(i_last_gnt), off, N_REQ));
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters.
// Optional transmitter watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned N_REQ       = DEF_N_REQ,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                    clk,
   input  logic                    Reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        done,
   output logic                    tx_start,
   output logic [DATA_W-1:0]       tx_data,
   input  logic                    tx_done_tick,
   output logic                    busy,
   output logic                    timeout_err
);

   localparam int unsigned      IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
   localparam logic [N_REQ-1:0] ONE_HOT  = N_REQ'(1);

   arb_state_e         r_state, w_state_d;
   logic [IDX_W-1:0]   r_winner, w_winner_d;
   logic [IDX_W-1:0]   r_last_gnt, w_last_gnt_d;
   logic [DATA_W-1:0]  r_tx_data, w_tx_data_d;
   logic [N_REQ-1:0]   r_gnt, w_gnt_d;
   logic [N_REQ-1:0]   r_done, w_done_d;
   logic               r_tx_start, w_tx_start_d;
   logic               r_busy, w_busy_d;
   logic               r_tmo_err, w_tmo_err_d;
   logic [IDX_W-1:0]   w_pick;
   logic               w_pick_valid;
   logic [DATA_W-1:0]  w_sel_data;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [CNT_W-1:0] r_tmo_cnt, w_tmo_cnt_d;
`else
   logic w_unused_tmo;
   assign w_unused_tmo = (TIMEOUT_CYC == 0);
`endif

   uart_rr_picker #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .i_req      (req),
      .i_last_gnt (r_last_gnt),
      .o_winner   (w_pick),
      .o_valid    (w_pick_valid)
   );

   always_comb begin
      w_sel_data = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (w_pick == IDX_W'(i)) w_sel_data = req_data[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      w_state_d    = r_state;
      w_winner_d   = r_winner;
      w_last_gnt_d = r_last_gnt;
      w_tx_data_d  = r_tx_data;
      w_gnt_d      = '0;
      w_done_d     = '0;
      w_tx_start_d = 1'b0;
      w_tmo_err_d  = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      w_tmo_cnt_d  = '0;
`endif
      case (r_state)
         StIdle: begin
            if (w_pick_valid) begin
               w_winner_d   = w_pick;
               w_tx_data_d  = w_sel_data;
               w_gnt_d      = ONE_HOT << w_pick;
               w_tx_start_d = 1'b1;
               w_state_d    = StLoad;
            end
         end
         StLoad: begin
            w_state_d = StWaitDone;
         end
         StWaitDone: begin
            if (tx_done_tick) begin
               w_done_d     = ONE_HOT << r_winner;
               w_last_gnt_d = r_winner;
               w_state_d    = StIdle;
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            else if (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               // Give up on the frame but still advance the pointer past the stuck requester.
               w_tmo_err_d  = 1'b1;
               w_last_gnt_d = r_winner;
               w_state_d    = StIdle;
            end else begin
               w_tmo_cnt_d = r_tmo_cnt + 1'b1;
            end
`endif
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   assign w_busy_d = (w_state_d != StIdle);

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_state    <= StIdle;
         r_winner   <= '0;
         r_last_gnt <= LAST_RST;
         r_tx_data  <= '0;
         r_gnt      <= '0;
         r_done     <= '0;
         r_tx_start <= 1'b0;
         r_busy     <= 1'b0;
         r_tmo_err  <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         r_tmo_cnt  <= '0;
`endif
      end else begin
         r_state    <= w_state_d;
         r_winner   <= w_winner_d;
         r_last_gnt <= w_last_gnt_d;
         r_tx_data  <= w_tx_data_d;
         r_gnt      <= w_gnt_d;
         r_done     <= w_done_d;
         r_tx_start <= w_tx_start_d;
         r_busy     <= w_busy_d;
         r_tmo_err  <= w_tmo_err_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
         r_tmo_cnt  <= w_tmo_cnt_d;
`endif
      end
   end

   assign gnt         = r_gnt;
   assign done        = r_done;
   assign tx_start    = r_tx_start;
   assign tx_data     = r_tx_data;
   assign busy        = r_busy;
   assign timeout_err = r_tmo_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter; covers the timeout path when
// UART_TX_ARB_TIMEOUT_EN is defined, otherwise checks the indefinite wait.
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          Reset;
   logic [N-1:0]  req;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]  gnt;
   logic [N-1:0]  done;
   logic          tx_start;
   logic [DW-1:0] tx_data;
   logic          tx_done_tick;
   logic          busy;
   logic          timeout_err;

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          q_gnt[$];
   int            q_done[$];
   logic [DW-1:0] cur_data;
   int            checks = 0;
   int            errors = 0;

   uart_tx_arbiter #(
      .N_REQ       (N),
      .DATA_W      (DW),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk          (clk),
      .Reset        (Reset),
      .req          (req),
      .req_data     (req_data),
      .gnt          (gnt),
      .done         (done),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .tx_done_tick (tx_done_tick),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int idx, input logic [DW-1:0] d, input bit push);
      req[idx] = 1'b1;
      req_data[idx*DW +: DW] = d;
      if (push) q_gnt.push_back('{idx, d});
   endtask

   task automatic wait_gnt(input string tag, input int budget);
      int   n;
      exp_t e;
      n = 0;
      do begin
         tick();
         n++;
      end while (gnt == '0 && n < budget);
      if (q_gnt.size() == 0) begin
         chk({tag, " unexpected gnt"}, 32'(gnt), 32'd0);
         return;
      end
      e = q_gnt.pop_front();
      cur_data = e.data;
      chk({tag, " gnt"}, 32'(gnt), 32'd1 << e.idx);
      chk({tag, " tx_start"}, 32'(tx_start), 32'd1);
      chk({tag, " tx_data"}, 32'(tx_data), 32'(e.data));
      chk({tag, " busy"}, 32'(busy), 32'd1);
      q_done.push_back(e.idx);
   endtask

   task automatic pulse_done(input string tag);
      int idx;
      tx_done_tick = 1'b1;
      tick();
      tx_done_tick = 1'b0;
      idx = (q_done.size() != 0) ? q_done.pop_front() : 0;
      chk({tag, " done"}, 32'(done), 32'd1 << idx);
      chk({tag, " idle"}, 32'(busy), 32'd0);
   endtask

   // Called in the LOAD cycle; the first tick pulse lands in LOAD and must be ignored.
   task automatic finish_xfer(input string tag, input int delay);
      tx_done_tick = 1'b1;
      tick();
      tx_done_tick = 1'b0;
      chk({tag, " tick in LOAD ignored"}, 32'(done), 32'd0);
      chk({tag, " busy in WAIT_DONE"}, 32'(busy), 32'd1);
      repeat (delay) tick();
      chk({tag, " tx_data stable"}, 32'(tx_data), 32'(cur_data));
      chk({tag, " tx_start one-shot"}, 32'(tx_start), 32'd0);
      pulse_done(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1);
   end

   initial begin
      int   n;
      logic seen_err;

      Reset        = 1'b1;
      req          = '0;
      req_data     = '0;
      tx_done_tick = 1'b0;
      tick();
      tick();
      chk("rst gnt", 32'(gnt), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst tx_start", 32'(tx_start), 32'd0);
      chk("rst tx_data", 32'(tx_data), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst timeout_err", 32'(timeout_err), 32'd0);
      Reset = 1'b0;
      tick();
      tick();
      chk("idle busy", 32'(busy), 32'd0);

      // Single requester 2 with 0xA5.
      req_data = N*DW'($urandom());
      set_req(2, 8'hA5, 1'b1);
      wait_gnt("single", 4);
      req[2] = 1'b0;
      finish_xfer("single", 10);
      tick();
      chk("single done one-shot", 32'(done), 32'd0);

      // Request withdrawn between edges never gets granted.
      req[0] = 1'b1;
      #2;
      req[0] = 1'b0;
      tick();
      chk("dropped gnt", 32'(gnt), 32'd0);
      chk("dropped busy", 32'(busy), 32'd0);

      // Fresh pointer, all four held: 0,1,2,3,0 back-to-back.
      Reset = 1'b1;
      #2;
      Reset = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 8'h10 + 8'(i), 1'b0);
      for (int k = 0; k < 5; k++) q_gnt.push_back('{k % N, 8'h10 + 8'(k % N)});
      for (int k = 0; k < 5; k++) begin
         wait_gnt("rr all", (k == 0) ? 3 : 1);
         if (k == 4) req = '0;
         finish_xfer("rr all", 2 + k);
      end
      tick();
      chk("rr all quiet gnt", 32'(gnt), 32'd0);
      chk("rr all quiet busy", 32'(busy), 32'd0);

      // Requester 1 arrives while 3 is on the wire.
      set_req(3, 8'h3C, 1'b1);
      wait_gnt("late", 3);
      req[3] = 1'b0;
      tick();
      set_req(1, 8'h5A, 1'b1);
      repeat (3) tick();
      chk("late waits", 32'(gnt), 32'd0);
      pulse_done("late 3");
      wait_gnt("late 1", 1);
      req[1] = 1'b0;
      finish_xfer("late 1", 3);

      // Pointer at 1: 2 beats 0, then 0 via wrap.
      set_req(0, 8'hE0, 1'b0);
      set_req(2, 8'hE2, 1'b1);
      q_gnt.push_back('{0, 8'hE0});
      wait_gnt("wrap 2", 3);
      req[2] = 1'b0;
      finish_xfer("wrap 2", 2);
      wait_gnt("wrap 0", 1);
      req[0] = 1'b0;
      finish_xfer("wrap 0", 2);

      // Reset in WAIT_DONE abandons the transfer.
      set_req(1, 8'h77, 1'b1);
      wait_gnt("abandon", 3);
      req[1] = 1'b0;
      tick();
      tick();
      #3;
      Reset = 1'b1;
      #1;
      chk("async rst gnt", 32'(gnt), 32'd0);
      chk("async rst done", 32'(done), 32'd0);
      chk("async rst tx_start", 32'(tx_start), 32'd0);
      chk("async rst tx_data", 32'(tx_data), 32'd0);
      chk("async rst busy", 32'(busy), 32'd0);
      chk("async rst timeout_err", 32'(timeout_err), 32'd0);
      q_done.delete();
      set_req(0, 8'h0F, 1'b1);
      set_req(2, 8'h2F, 1'b1);
      tick();
      Reset = 1'b0;
      chk("post rst no done", 32'(done), 32'd0);
      wait_gnt("post rst lowest", 3);
      req[0] = 1'b0;
      finish_xfer("post rst lowest", 2);
      wait_gnt("post rst next", 1);
      req[2] = 1'b0;
      finish_xfer("post rst next", 2);

      // Transmitter never answers.
      set_req(0, 8'hC3, 1'b1);
      wait_gnt("stall", 3);
      req[0] = 1'b0;
      set_req(2, 8'h99, 1'b1);
`ifdef UART_TX_ARB_TIMEOUT_EN
      n = 0;
      do begin
         tick();
         n++;
      end while (!timeout_err && n < 40);
      chk("timeout latency", 32'(n), 32'(TMO + 1));
      chk("timeout_err pulse", 32'(timeout_err), 32'd1);
      chk("timeout no done", 32'(done), 32'd0);
      chk("timeout idle", 32'(busy), 32'd0);
      void'(q_done.pop_front());
      wait_gnt("after timeout", 1);
      req[2] = 1'b0;
      tick();
      chk("timeout_err one-shot", 32'(timeout_err), 32'd0);
      pulse_done("after timeout");
`else
      seen_err = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         seen_err = seen_err | timeout_err;
      end
      chk("stall busy", 32'(busy), 32'd1);
      chk("stall no timeout_err", 32'(seen_err), 32'd0);
      chk("stall no gnt", 32'(gnt), 32'd0);
      pulse_done("stall");
      wait_gnt("after stall", 1);
      req[2] = 1'b0;
      finish_xfer("after stall", 2);
`endif
      chk("scoreboard drained", 32'(q_gnt.size() + q_done.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, is the number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter DATA_W, default 8, is the payload width, equal to transmitter data_in width.
REQ-003 Parameter TIMEOUT_CYC, default 4096, is the max clk cycles awaiting tx_done_tick (only with REQ-029 macro).
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  N_REQ  per-requester transmit request, level.
REQ-007 req_data  input  N_REQ*DATA_W  flattened payloads, requester i at bits [i*DATA_W +: DATA_W].
REQ-008 gnt  output  N_REQ  one-hot, one-cycle pulse: requester's byte accepted.
REQ-009 done  output  N_REQ  one-hot, one-cycle pulse: requester's byte fully transmitted.
REQ-010 tx_start  output  1  one-cycle start pulse to the transmitter.
REQ-011 tx_data  output  DATA_W  latched payload to the transmitter; stable from tx_start until exit from WAIT_DONE.
REQ-012 tx_done_tick  input  1  transmitter frame-complete pulse.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 timeout_err  output  1  one-cycle pulse on transmitter timeout.

Function
REQ-015 FSM states SHALL be IDLE, LOAD and WAIT_DONE; all outputs registered.
REQ-016 IDLE: if req nonzero at an edge, SHALL select winner w by round-robin, latch req_data slice w into tx_data, go to LOAD; else stay.
REQ-017 Round-robin: search starts at last_gnt+1 mod N_REQ, upward with wrap; first set req bit wins.
REQ-018 LOAD (exactly one cycle): gnt[w]=1 and tx_start=1 in the same cycle; next state WAIT_DONE.
REQ-019 WAIT_DONE: on tx_done_tick, done[w] pulses in the following cycle, last_gnt<=w, next state IDLE.
REQ-020 Latency: req seen at edge k -> gnt/tx_start high in cycle k..k+1 -> earliest next grant 1 cycle after done.
REQ-021 Requester SHALL hold req and req_data stable until gnt; req still high in IDLE after gnt is a new request.
REQ-022 Requests arriving in LOAD/WAIT_DONE SHALL wait; none are dropped while req held.
REQ-023 tx_done_tick in IDLE or LOAD SHALL be ignored.
REQ-024 Simultaneous req on all lines with last_gnt=N_REQ-1 SHALL grant requester 0.
REQ-025 Request dropped before sampling in IDLE SHALL produce no grant; pointer unchanged.

Reset
REQ-026 Reset SHALL force IDLE, gnt=0, done=0, tx_start=0, tx_data=0, busy=0, timeout_err=0, last_gnt=N_REQ-1, timeout counter 0.
REQ-027 Reset mid-LOAD/WAIT_DONE SHALL abandon the transfer with no done pulse.
REQ-028 After Reset deassertion, first grant to lowest-indexed active requester.

Configuration
REQ-029 Macro UART_TX_ARB_TIMEOUT_EN defined: WAIT_DONE cycle counter; at TIMEOUT_CYC cycles without tx_done_tick -> timeout_err pulse, no done, last_gnt<=w, state IDLE.
REQ-030 Macro undefined: no counter, WAIT_DONE waits indefinitely, timeout_err tied 0 (port retained).

Structure
REQ-031 Package uart_arb_pkg SHALL hold the state enum and default parameter constants.
REQ-032 Sub-module uart_rr_picker SHALL implement combinational round-robin selection (req, last_gnt -> winner index, valid).

Verification
REQ-033 Single req[2]=1, data 0xA5 -> gnt[2] and tx_start same cycle, tx_data=0xA5; tx_done_tick after 10 cycles -> done[2] next cycle.
REQ-034 req=4'b1111 held, done returned per transfer -> grant order 0,1,2,3,0.
REQ-035 req[1] raised during WAIT_DONE of requester 3 -> gnt[1] issued 1 cycle after done[3], pointer wraps correctly.
REQ-036 Reset asserted in WAIT_DONE -> all outputs 0 asynchronously, no done; next grant to lowest active requester.
REQ-037 Macro defined, TIMEOUT_CYC=16, no tx_done_tick -> timeout_err pulse 16 cycles after LOAD, IDLE, next requester served; macro undefined -> stays busy.
